// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int ENTRY_W = 2 * XLEN;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, word} entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the read port is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching fetch stage: owns the fetch PC, issues imem requests, buffers words for the core.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_nxt;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0]   stale_pc, stale_pc_nxt;
    logic              run;
    logic              push;
    logic              pop;
    logic              fill_last;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [ENTRY_W-1:0] head;

    // Both handshakes complete on a clock edge where the producer's valid/req and the
    // consumer's ready/ack are high together; the producer holds its payload until then.
    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    assign fill_last   = (count == CW'(DEPTH - 1)) && !pop;
    assign {instr_pc, instr} = head;
    assign dbg_state   = state;

    // Holds the request low for the first cycle so reset release never coincides with a request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            stale_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            stale_pc <= stale_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        stale_pc_nxt = stale_pc;
        imem_req     = 1'b0;
        imem_addr    = fetch_pc;
        push         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!full || pop) state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = run;
                if (run && imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (fill_last) state_nxt = IDLE;
                end
            end
            DISCARD: begin
                imem_req  = run;
                imem_addr = stale_pc;
                if (run && imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // An outstanding request cannot be withdrawn, so it is completed at its old address and dropped.
        if (redirect) begin
            push         = 1'b0;
            fetch_pc_nxt = word_align(redirect_pc);
            case (state)
                FETCH: begin
                    if (imem_req && !imem_ack) begin
                        state_nxt    = DISCARD;
                        stale_pc_nxt = fetch_pc;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
                IDLE:    state_nxt = FETCH;
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .wdata ({fetch_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus randomized traffic for instr_fetch_unit against a stream-level model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;
    int xfer_base = 0;
    int lat_min = 0;
    int lat_max = 0;
    int wait_cnt;

    // Monitor state: next PC the core must consume, plus last-cycle observations.
    logic [31:0] exp_pc = RST_PC;
    logic        prev_redir = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_ipc = 32'h0;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // Memory: each request waits wait_cnt cycles, then acks with combinational data.
    always @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= lat_min;
        else if (imem_req && imem_ack) wait_cnt <= $urandom_range(lat_max, lat_min);
        else if (imem_req && wait_cnt > 0) wait_cnt <= wait_cnt - 1;
    end
    assign imem_ack   = imem_req && (wait_cnt == 0);
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        step();
        step();
    endtask

    // Stream-level scoreboard: the core must see consecutive words from the latest redirect target.
    always @(negedge clk) begin
        if (!rst) begin
            exp_pc     = RST_PC;
            prev_redir = 1'b0;
            prev_hold  = 1'b0;
            prev_pend  = 1'b0;
        end else begin
            if (prev_redir) chk("flush_valid", 32'(instr_valid), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_pc", instr_pc, prev_ipc);
                chk("hold_instr", instr, prev_instr);
            end
            if (prev_pend) chk("req_addr_hold", imem_addr, prev_addr);
            if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (instr_valid && instr_ready) begin
                chk("xfer_pc", instr_pc, exp_pc);
                chk("xfer_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_redir = redirect;
            prev_hold  = instr_valid && !instr_ready && !redirect;
            prev_pend  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            prev_instr = instr;
            prev_ipc   = instr_pc;
        end
    end

    initial begin
        // Reset values and zero-wait streaming.
        lat_min = 0; lat_max = 0; instr_ready = 1'b1;
        do_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(FETCH));
        rst = 1'b1;
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_valid0", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_pc0", instr_pc, 32'h0);
        chk("t1_instr0", instr, mem_word(32'h0));
        for (int k = 1; k < 4; k++) begin
            step();
            chk("t1_pc", instr_pc, 32'(4 * k));
        end

        // Consumer stalled: FIFO fills, request drops, then resumes after the first pop.
        instr_ready = 1'b0;
        do_reset();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_head", instr_pc, 32'h0);
        chk("t2_state", 32'(dbg_state), 32'(IDLE));
        step();
        chk("t2_req_still", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        step();
        chk("t2_req_back", 32'(imem_req), 32'd1);
        chk("t2_addr", imem_addr, 32'h10);
        chk("t2_head_next", instr_pc, 32'h4);

        // Three-cycle memory, redirect mid-request.
        lat_min = 2; lat_max = 2;
        do_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t3_first", instr_pc, 32'h0);
        chk("t3_addr4", imem_addr, 32'h4);
        step();
        chk("t3_valid_pre", 32'(instr_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("t3_discard_state", 32'(dbg_state), 32'(DISCARD));
        chk("t3_stale_addr", imem_addr, 32'h4);
        chk("t3_stale_req", 32'(imem_req), 32'd1);
        step();
        chk("t3_new_addr", imem_addr, 32'h100);
        chk("t3_no_stale", 32'(instr_valid), 32'd0);
        step();
        step();
        chk("t3_wait_valid", 32'(instr_valid), 32'd0);
        step();
        chk("t3_new_valid", 32'(instr_valid), 32'd1);
        chk("t3_new_pc", instr_pc, 32'h100);
        chk("t3_new_instr", instr, mem_word(32'h100));

        // Redirect coincident with ack and pop, then PC wrap-around.
        lat_min = 0; lat_max = 0;
        do_reset();
        rst = 1'b1;
        step();
        step();
        chk("t4_valid", 32'(instr_valid), 32'd1);
        chk("t4_ack", 32'(imem_ack), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("t4_empty", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h40);
        step();
        chk("t4_pc", instr_pc, 32'h40);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_addr_wrap", imem_addr, 32'h0);
        chk("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_pc_wrap", instr_pc, 32'h0);

        // Asynchronous reset with buffered entries, then while discarding.
        instr_ready = 1'b0;
        do_reset();
        rst = 1'b1;
        step();
        step();
        lat_min = 6; lat_max = 6;
        step();
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        chk("t6_pre_addr", imem_addr, 32'h8);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_addr", imem_addr, RST_PC);
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_instr", instr, 32'd0);
        chk("t6_rst_ipc", instr_pc, 32'd0);
        step();
        rst = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("t6_discard", 32'(dbg_state), 32'(DISCARD));
        chk("t6_dis_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_dis_rst_req", 32'(imem_req), 32'd0);
        chk("t6_dis_rst_addr", imem_addr, RST_PC);
        chk("t6_dis_rst_state", 32'(dbg_state), 32'(FETCH));
        step();

        // Randomized traffic checked by the stream scoreboard.
        lat_min = 0; lat_max = 3;
        do_reset();
        rst = 1'b1;
        xfer_base = n_xfer;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            redirect    = ($urandom_range(31, 0) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("liveness", 32'(n_xfer - xfer_base >= 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
